// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : Pipe_Buf_Reg_PKG
// Description : Shared definitions for the pipeline buffer registers and the
//               hazard controller: controller state encoding, forwarding-mux
//               select codes and the write-back source code for pc_plus_4.
// Revision    : 1.0  initial release
// ============================================================================
package Pipe_Buf_Reg_PKG;

    // Hazard controller FSM encoding.
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        WAIT  = 2'b01,
        ERROR = 2'b10
    } hz_state_e;

    // EX operand forwarding selects.
    localparam logic [1:0] FWD_REG = 2'b00;  // register-file value
    localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB write-back value
    localparam logic [1:0] FWD_ALU = 2'b10;  // EX/MEM ALU_result
    localparam logic [1:0] FWD_PC4 = 2'b11;  // EX/MEM pc_plus_4 (jal/jalr link)

    // ex_mem_reg_wb_src code meaning "write back pc_plus_4".
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Forwarding select for one EX operand. The youngest producer
//               (EX/MEM) wins over MEM/WB; x0 is never forwarded.
// Ports       : i_rs                 - ID/EX source register of this operand
//               i_ex_mem_rd          - EX/MEM destination register
//               i_ex_mem_reg_write   - EX/MEM writes the register file
//               i_ex_mem_reg_wb_src  - EX/MEM write-back source select
//               i_mem_wb_rd          - MEM/WB destination register
//               i_mem_wb_reg_write   - MEM/WB writes the register file
//               o_fwd                - operand mux select (FWD_* codes)
// Revision    : 1.0  initial release
// ============================================================================
module fwd_unit
    import Pipe_Buf_Reg_PKG::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_ex_mem_rd,
    input  logic       i_ex_mem_reg_write,
    input  logic [1:0] i_ex_mem_reg_wb_src,
    input  logic [4:0] i_mem_wb_rd,
    input  logic       i_mem_wb_reg_write,
    output logic [1:0] o_fwd
);

    logic w_ex_hit;
    logic w_wb_hit;

    assign w_ex_hit = i_ex_mem_reg_write && (i_ex_mem_rd == i_rs);
    assign w_wb_hit = i_mem_wb_reg_write && (i_mem_wb_rd == i_rs);

    always_comb begin
        o_fwd = FWD_REG;
        if (i_rs != 5'd0) begin
            if (w_ex_hit) begin
                // A link instruction in EX/MEM has pc_plus_4 as its result.
                o_fwd = (i_ex_mem_reg_wb_src == WB_SRC_PC4) ? FWD_PC4 : FWD_ALU;
            end else if (w_wb_hit) begin
                o_fwd = FWD_WB;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard and stall controller for the five-stage pipeline.
//               Drives buffer-register enables, flushes, EX forwarding and
//               the data-memory handshake; times out slow memory accesses.
// Ports       : clk, rst_n                        - clock, async active-low reset
//               if_id_*/id_ex_*/ex_mem_*/mem_wb_* - buffer register fields
//               branch_taken                      - EX resolved a taken branch
//               dmem_ack                          - data memory access done
//               *_write_en                        - buffer-register enables
//               if_id_flush, id_ex_flush          - load NOP into IF/ID, ID/EX
//               mem_wb_bubble                     - load NOP into MEM/WB
//               forward_a, forward_b              - EX operand selects
//               dmem_req                          - data memory request
//               mem_error                         - sticky memory timeout
//               stall_cycles                      - saturating frozen-cycle count
// Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic [4:0]       id_ex_rs1,
    input  logic [4:0]       id_ex_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             branch_taken,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ex_mem_reg_write,
    input  logic [1:0]       ex_mem_reg_wb_src,
    input  logic             ex_mem_mem_read,
    input  logic             ex_mem_mem_write,
    input  logic [4:0]       mem_wb_rd,
    input  logic             mem_wb_reg_write,
    input  logic             dmem_ack,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_write_en,
    output logic             ex_mem_write_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             dmem_req,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0]       c_ST_RUN   = 2'(RUN);
    localparam logic [1:0]       c_ST_WAIT  = 2'(WAIT);
    localparam logic [1:0]       c_ST_ERROR = 2'(ERROR);
    localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_mem_error;
    logic [CNT_W-1:0] r_stall_cycles;

    logic             w_access;
    logic             w_err;
    logic             w_freeze;
    logic             w_load_use;
    logic             w_stall;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    assign w_access   = ex_mem_mem_read | ex_mem_mem_write;
    assign w_err      = (r_state == c_ST_ERROR);
    assign w_freeze   = (w_access & ~dmem_ack & ~w_err) | w_err;
    assign w_load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                        ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    // A taken branch squashes the dependent instruction, so no bubble then.
    assign w_stall    = w_freeze | (w_load_use & ~branch_taken);

    fwd_unit u_fwd_a (
        .i_rs                (id_ex_rs1),
        .i_ex_mem_rd         (ex_mem_rd),
        .i_ex_mem_reg_write  (ex_mem_reg_write),
        .i_ex_mem_reg_wb_src (ex_mem_reg_wb_src),
        .i_mem_wb_rd         (mem_wb_rd),
        .i_mem_wb_reg_write  (mem_wb_reg_write),
        .o_fwd               (w_fwd_a)
    );

    fwd_unit u_fwd_b (
        .i_rs                (id_ex_rs2),
        .i_ex_mem_rd         (ex_mem_rd),
        .i_ex_mem_reg_write  (ex_mem_reg_write),
        .i_ex_mem_reg_wb_src (ex_mem_reg_wb_src),
        .i_mem_wb_rd         (mem_wb_rd),
        .i_mem_wb_reg_write  (mem_wb_reg_write),
        .o_fwd               (w_fwd_b)
    );

    // Pipeline control. While reset is held the whole pipe is filled with
    // NOPs and nothing advances.
    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        id_ex_write_en  = 1'b1;
        ex_mem_write_en = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        mem_wb_bubble   = 1'b0;
        dmem_req        = w_access & ~w_err;
        forward_a       = w_fwd_a;
        forward_b       = w_fwd_b;
        if (!rst_n) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            mem_wb_bubble   = 1'b1;
            dmem_req        = 1'b0;
            forward_a       = FWD_REG;
            forward_b       = FWD_REG;
        end else if (w_freeze) begin
            // A branch seen here stays in ID/EX and flushes once unfrozen.
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            mem_wb_bubble   = 1'b1;
        end else if (branch_taken) begin
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
        end else if (w_load_use) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_flush     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_ST_RUN;
            r_timer        <= '0;
            r_mem_error    <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_access && !dmem_ack) begin
                        r_state <= c_ST_WAIT;
                        r_timer <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                c_ST_WAIT: begin
                    if (dmem_ack) begin
                        r_state <= c_ST_RUN;
                        r_timer <= '0;
                    end else if (r_timer == c_TIMEOUT) begin
                        r_state     <= c_ST_ERROR;
                        r_mem_error <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_ST_ERROR: begin
                    r_state <= c_ST_ERROR;
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_timer <= '0;
                end
            endcase

            if (w_stall && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign mem_error    = r_mem_error;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl: table of single-
//               cycle control vectors plus directed multi-cycle sequences
//               (load-use, slow memory, frozen branch, timeout, reset).
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_TMO = 4;
    localparam int c_CW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic id_ex_mem_read, branch_taken;
    logic [4:0] ex_mem_rd;
    logic ex_mem_reg_write;
    logic [1:0] ex_mem_reg_wb_src;
    logic ex_mem_mem_read, ex_mem_mem_write;
    logic [4:0] mem_wb_rd;
    logic mem_wb_reg_write, dmem_ack;
    logic pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en;
    logic if_id_flush, id_ex_flush, mem_wb_bubble, dmem_req, mem_error;
    logic [1:0] forward_a, forward_b;
    logic [c_CW-1:0] stall_cycles;

    // {pc, if_id, id_ex, ex_mem enables, if_id_flush, id_ex_flush,
    //  mem_wb_bubble, dmem_req, forward_a, forward_b}
    logic [11:0] act;
    assign act = {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
                  if_id_flush, id_ex_flush, mem_wb_bubble, dmem_req,
                  forward_a, forward_b};

    int n_checks = 0;
    int n_errors = 0;
    logic [c_CW-1:0] exp_stall;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(c_TMO), .CNT_W(c_CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_mem_read(id_ex_mem_read), .branch_taken(branch_taken),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_reg_wb_src(ex_mem_reg_wb_src),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
        .dmem_ack(dmem_ack),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble),
        .forward_a(forward_a), .forward_b(forward_b),
        .dmem_req(dmem_req), .mem_error(mem_error),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ifr1, ifr2, exr1, exr2, exrd;
        logic        ld, br;
        logic [4:0]  emrd;
        logic        emwr;
        logic [1:0]  emsrc;
        logic        mrd, mwr;
        logic [4:0]  wbrd;
        logic        wbwr, ack;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string nm, input logic [15:0] a, input logic [15:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [c_CW-1:0] sat_inc(input logic [c_CW-1:0] x);
        return (x == {c_CW{1'b1}}) ? x : x + 1'b1;
    endfunction

    task automatic clear_in();
        if_id_rs1 = 0; if_id_rs2 = 0; id_ex_rs1 = 0; id_ex_rs2 = 0; id_ex_rd = 0;
        id_ex_mem_read = 0; branch_taken = 0; ex_mem_rd = 0; ex_mem_reg_write = 0;
        ex_mem_reg_wb_src = 0; ex_mem_mem_read = 0; ex_mem_mem_write = 0;
        mem_wb_rd = 0; mem_wb_reg_write = 0; dmem_ack = 0;
    endtask

    task automatic apply(input vec_t v);
        if_id_rs1 = v.ifr1; if_id_rs2 = v.ifr2; id_ex_rs1 = v.exr1; id_ex_rs2 = v.exr2;
        id_ex_rd = v.exrd; id_ex_mem_read = v.ld; branch_taken = v.br;
        ex_mem_rd = v.emrd; ex_mem_reg_write = v.emwr; ex_mem_reg_wb_src = v.emsrc;
        ex_mem_mem_read = v.mrd; ex_mem_mem_write = v.mwr;
        mem_wb_rd = v.wbrd; mem_wb_reg_write = v.wbwr; dmem_ack = v.ack;
    endtask

    // Called just after a rising edge with inputs already set: checks the
    // control outputs mid-cycle, models the stall counter, advances a cycle.
    task automatic cyc(input string nm, input logic [11:0] e);
        @(negedge clk);
        check(nm, {4'h0, act}, {4'h0, e});
        if (!e[11]) exp_stall = sat_inc(exp_stall);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          ifr1 ifr2 exr1 exr2 exrd ld br emrd emwr emsrc mrd mwr wbrd wbwr ack exp
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 12'hF00, "nop"};
        vecs[1]  = '{0, 0, 5, 0, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 0, 0, 12'hF08, "fwd_a_alu"};
        vecs[2]  = '{0, 0, 5, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 5, 1, 0, 12'hF04, "fwd_a_wb"};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1, 0, 12'hF00, "fwd_x0"};
        vecs[4]  = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 2'b10, 0, 0, 0, 0, 0, 12'hF0C, "fwd_a_pc4"};
        vecs[5]  = '{0, 0, 0, 6, 0, 0, 0, 6, 1, 2'b01, 0, 0, 0, 0, 0, 12'hF02, "fwd_b_alu"};
        vecs[6]  = '{0, 0, 7, 7, 0, 0, 0, 7, 1, 2'b00, 0, 0, 7, 1, 0, 12'hF0A, "fwd_exmem_prio"};
        vecs[7]  = '{0, 0, 9, 0, 0, 0, 0, 9, 0, 2'b00, 0, 0, 9, 1, 0, 12'hF04, "fwd_exmem_nowr"};
        vecs[8]  = '{7, 0, 0, 0, 7, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h340, "load_use_rs1"};
        vecs[9]  = '{0, 7, 0, 0, 7, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h340, "load_use_rs2"};
        vecs[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 12'hF00, "load_rd_x0"};
        vecs[11] = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 12'hF00, "no_load"};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 12'hFC0, "branch"};
        vecs[13] = '{7, 0, 0, 0, 7, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 12'hFC0, "branch_over_lu"};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 1, 12'hF10, "mem_single_cyc"};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 12'hF00, "ack_no_access"};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0, 1, 12'hFD0, "store_ack_branch"};

        // Reset with live inputs: everything must be gated to the NOP state.
        rst_n = 1'b0;
        clear_in();
        ex_mem_mem_read = 1; id_ex_rs1 = 3; ex_mem_rd = 3; ex_mem_reg_write = 1;
        exp_stall = '0;
        #12;
        check("reset_ctrl", {4'h0, act}, 16'h00E0);
        check("reset_mem_error", {15'h0, mem_error}, 16'h0);
        check("reset_stall", {12'h0, stall_cycles}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_in();
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i]);
            cyc(vecs[i].name, vecs[i].exp);
        end
        clear_in();
        @(negedge clk);
        check("stall_after_table", {12'h0, stall_cycles}, {12'h0, exp_stall});
        @(posedge clk);
        #1;

        // lw x7 in ID/EX, add x8,x7,x2 in IF/ID: one bubble, then WB forward.
        id_ex_mem_read = 1; id_ex_rd = 7; if_id_rs1 = 7; if_id_rs2 = 2;
        cyc("lu_bubble", 12'h340);
        clear_in();
        id_ex_rs1 = 7; id_ex_rs2 = 2; mem_wb_rd = 7; mem_wb_reg_write = 1;
        @(negedge clk);
        check("lu_stall_count", {12'h0, stall_cycles}, {12'h0, exp_stall});
        cyc("lu_then_fwd_wb", 12'hF04);

        // Store acknowledged on its third request cycle.
        clear_in();
        ex_mem_mem_write = 1;
        cyc("sw_wait1", 12'h030);
        cyc("sw_wait2", 12'h030);
        dmem_ack = 1;
        cyc("sw_ack", 12'hF10);
        clear_in();
        cyc("sw_done", 12'hF00);

        // Branch held while frozen, flushed in the ack cycle.
        ex_mem_mem_read = 1; branch_taken = 1;
        cyc("br_frozen", 12'h030);
        dmem_ack = 1;
        cyc("br_unfrozen", 12'hFD0);
        clear_in();
        @(negedge clk);
        check("stall_after_mem", {12'h0, stall_cycles}, {12'h0, exp_stall});
        @(posedge clk);
        #1;

        // Timeout: one RUN cycle plus timer 1..4 in WAIT, then ERROR.
        ex_mem_mem_read = 1;
        for (int k = 0; k <= c_TMO; k++) begin
            check("tmo_no_error_yet", {15'h0, mem_error}, 16'h0);
            cyc("tmo_wait", 12'h030);
        end
        check("tmo_mem_error", {15'h0, mem_error}, 16'h1);
        for (int k = 0; k < 12; k++) begin
            dmem_ack = k[0];
            cyc("err_absorbing", 12'h020);
        end
        check("err_mem_error_sticky", {15'h0, mem_error}, 16'h1);
        check("stall_saturated", {12'h0, stall_cycles}, {12'h0, exp_stall});

        // Asynchronous reset out of ERROR.
        #2;
        rst_n = 1'b0;
        #1;
        exp_stall = '0;
        check("rst_err_ctrl", {4'h0, act}, 16'h00E0);
        check("rst_err_mem_error", {15'h0, mem_error}, 16'h0);
        check("rst_err_stall", {12'h0, stall_cycles}, 16'h0);
        clear_in();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_rst_run", 12'hF00);

        // Asynchronous reset out of WAIT.
        ex_mem_mem_read = 1;
        cyc("enter_wait", 12'h030);
        #2;
        rst_n = 1'b0;
        #1;
        exp_stall = '0;
        check("rst_wait_ctrl", {4'h0, act}, 16'h00E0);
        check("rst_wait_stall", {12'h0, stall_cycles}, 16'h0);
        clear_in();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ex_mem_mem_read = 1; dmem_ack = 1;
        cyc("run_after_wait_rst", 12'hF10);
        clear_in();
        @(negedge clk);
        check("stall_after_wait_rst", {12'h0, stall_cycles}, {12'h0, exp_stall});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
